// File: rtl/lut_share_arbiter.sv
// Round-robin req/ack arbiter time-sharing one LUT4 cell.
// Ports: clk, rst_n, req, din -> ack, dout, busy, grant_id.
module lut #(
  parameter logic [15:0] LUT    = 16'h0000,
  parameter logic        NATIVE = 1'b1
) (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic o
);

  generate
    if (NATIVE) begin : g_mux
      logic [7:0] l1;
      logic [3:0] l2;
      logic [1:0] l3;
      always_comb begin
        for (int i = 0; i < 8; i++)
          l1[i] = a ? LUT[2*i+1] : LUT[2*i];
        for (int i = 0; i < 4; i++)
          l2[i] = b ? l1[2*i+1] : l1[2*i];
        for (int i = 0; i < 2; i++)
          l3[i] = c ? l2[2*i+1] : l2[2*i];
        o = d ? l3[1] : l3[0];
      end
    end else begin : g_idx
      assign o = LUT[{d, c, b, a}];
    end
  endgenerate

endmodule

module lut_share_arbiter #(
  parameter int          N_REQ  = 4,
  parameter int          SETTLE = 2,
  parameter logic [15:0] LUT    = 16'h0000,
  parameter logic        NATIVE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [4*N_REQ-1:0]       din,
  output logic [N_REQ-1:0]         ack,
  output logic                     dout,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACK
  } state_t;

  state_t         state, state_d;
  logic [GW-1:0]  g;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  pick;
  logic           pick_v;
  logic [3:0]     lut_in;
  logic [3:0]     cnt;
  logic           lut_o;
  logic           do_grant;
  logic           do_dec;
  logic           do_cap;
  logic           do_rel;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    pick_v = 1'b0;
    pick   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        pick_v = 1'b1;
        pick   = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Abort takes priority over capture in SETTLE.
  always_comb begin
    state_d  = state;
    do_grant = 1'b0;
    do_dec   = 1'b0;
    do_cap   = 1'b0;
    do_rel   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pick_v) begin
          do_grant = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!req[g]) begin
          do_rel  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt == 4'd0) begin
          do_cap  = 1'b1;
          state_d = S_ACK;
        end else begin
          do_dec = 1'b1;
        end
      end
      S_ACK: begin
        if (!req[g]) begin
          do_rel  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g      <= '0;
      ptr    <= '0;
      lut_in <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
      ack    <= '0;
    end else begin
      if (do_grant) begin
        g      <= pick;
        lut_in <= din[4*pick +: 4];
        cnt    <= 4'(SETTLE - 1);
      end
      if (do_dec) cnt <= cnt - 4'd1;
      if (do_cap) begin
        dout <= lut_o;
        ack  <= ONE << g;
      end
      if (do_rel) begin
        ack <= '0;
        ptr <= (g == GW'(N_REQ - 1)) ? '0
             : g + GW'(1);
      end
    end
  end

  lut #(
    .LUT    (LUT),
    .NATIVE (NATIVE)
  ) u_lut (
    .a (lut_in[0]),
    .b (lut_in[1]),
    .c (lut_in[2]),
    .d (lut_in[3]),
    .o (lut_o)
  );

  assign busy     = (state != S_IDLE);
  assign grant_id = g;

endmodule

// File: doc/lut_share_arbiter.md
# lut_share_arbiter

Round-robin arbiter that time-shares one `lut` cell among `N_REQ` requesters using a four-phase req/ack handshake. It grants one requester and drives that requester's `{d,c,b,a}` into the shared `lut`. It then waits a programmable settle interval covering the cell's input-to-output delay (up to 1285 ps in simulation), registers the result and acknowledges. It sits between synchronous client logic and the loop-broken LUT datapath, so a single physical LUT serves several consumers.

## Interface
- `N_REQ`, 4: number of requesters, legal 2..8
- `SETTLE`, 2: clock edges between applying LUT inputs and capturing `o`, legal 1..15
- `LUT`, 16'h0000: truth table passed to the shared `lut` instance
- `NATIVE`, 1'b1: passed to the shared `lut` instance
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request, four-phase
- `din`  in  4*N_REQ  requester i inputs at `din[4*i+3:4*i]` = {d,c,b,a}
- `ack`  out  N_REQ  per-requester acknowledge, one-hot or zero
- `dout`  out  1  registered LUT result, valid while any `ack` high
- `busy`  out  1  high whenever state is not IDLE
- `grant_id`  out  $clog2(N_REQ)  index of current grantee, valid while `busy`

## Operation
- States: IDLE, SETTLE, ACK.
- IDLE
  - On an edge with any `req` high, select the first set bit at or after `ptr`, wrapping modulo N_REQ.
  - Register `g`, `lut_in <= din[g]`, `cnt <= SETTLE-1`, go to SETTLE.
- SETTLE
  - `lut_in` drives the shared `lut` continuously.
  - Edge with `cnt != 0`: decrement `cnt`.
  - Edge with `cnt == 0`: `dout <= o`, `ack[g] <= 1`, go to ACK.
- ACK
  - Hold `ack[g]` and `dout`.
  - Edge with `req[g]` low: `ack[g] <= 0`, `ptr <= (g+1) mod N_REQ`, go to IDLE.
- Abort: an edge in SETTLE with `req[g]` low returns to IDLE. No ack is issued, `ptr <= (g+1) mod N_REQ`, and `dout` is unchanged.
- `din[g]` is sampled once, at grant. Later changes are ignored until the next grant.
- Requests from non-granted requesters are held pending. They are never dropped or acknowledged out of turn.
- `ptr` wraps from N_REQ-1 to 0.

## Timing
- Reset (async assert, sync release) forces:
  - state=IDLE, `ack`=0, `dout`=0, `busy`=0, `grant_id`=0
  - `ptr`=0, `lut_in`=0, `cnt`=0
- Reset asserted mid-transaction drops `ack` immediately with no completion. Requesters must restart.
- Latency: grant on edge E0, `ack[g]` and `dout` valid after edge E0+SETTLE. SETTLE=1 means ack after the next edge.
- Release: `ack[g]` falls on the first edge that samples `req[g]` low in ACK.
- Minimum one IDLE cycle between transactions, so back-to-back grant spacing is SETTLE+2 edges plus requester release time.
- Simultaneous requests on the same edge resolve strictly by `ptr` order. `req` rising on the release edge is seen in the following IDLE cycle.
- The clock period times SETTLE must exceed the LUT input-to-output delay. The block does not check this.
- `busy` rises on E0 and falls on the release edge. `grant_id` updates on E0 only.

## Test plan
- Single request, LUT=16'h6996, SETTLE=2, req[1]=1, din[7:4]=4'b0111:
  - `ack[1]` rises 2 edges after grant, `dout`=1.
  - Drop req[1]: ack falls next edge, `ptr`=2.
- All four req high from reset, each released one cycle after its ack:
  - Grants in order 0,1,2,3, then 0 again if req[0] is reasserted.
  - Exactly one `ack` high at any time.
- Abort, SETTLE=4: req[2] falls two edges after grant:
  - No ack, state IDLE, `ptr`=3, `dout` unchanged.
  - Pending req[3] granted next.
- Reset mid-ACK with `ack[0]`=1, `dout`=1: `rst_n` low clears `ack`, `dout` and `busy` asynchronously, and `ptr` returns to 0.
- Truth-table sweep, SETTLE=1, LUT=16'hA5C3:
  - Requester 0 issues all 16 `din` values sequentially.
  - Each `dout` equals LUT bit `din`, and each ack arrives 1 edge after grant.
- `din` change after grant: din[3:0] goes from 4'b0011 to 4'b0111 during SETTLE with LUT=16'h6996 → `dout`=0 (sampled value).
